// File: rtl/out_frame_latch.sv
// ----------------------------------------------------------------------------
// out_frame_latch
//   Serial-to-parallel output stage. Receives FRAME_BITS-bit frames over a
//   3-wire SPI-like link (mode 0, MSB first), checks the 4'hA sync nibble and
//   even parity, and holds the last valid WIDTH-bit payload on OUT_DATA. A
//   watchdog forces SAFE_VALUE when no valid frame arrives for WDT_CYCLES
//   clocks (WDT_CYCLES == 0 disables it).
//
// Ports
//   CLK        in   system clock, all state on rising edge
//   RST_N      in   asynchronous active-low reset
//   SCK        in   serial clock, asynchronous to CLK
//   MOSI       in   serial data, sampled on SCK rise
//   CS_N       in   frame select, active low
//   OUT_DATA   out  latched output value
//   FRAME_OK   out  1-cycle pulse, valid frame committed
//   FRAME_ERR  out  1-cycle pulse, frame rejected
//   WDT_TRIP   out  level, watchdog expired; cleared by next valid frame
// ----------------------------------------------------------------------------
module out_frame_latch #(
   parameter int unsigned      WIDTH      = 9,
   parameter logic [WIDTH-1:0] SAFE_VALUE = WIDTH'(0),
   parameter int unsigned      WDT_W      = 20,
   parameter logic [WDT_W-1:0] WDT_CYCLES = WDT_W'(500000)
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             SCK,
   input  logic             MOSI,
   input  logic             CS_N,
   output logic [WIDTH-1:0] OUT_DATA,
   output logic             FRAME_OK,
   output logic             FRAME_ERR,
   output logic             WDT_TRIP
);

   localparam int unsigned FRAME_BITS = WIDTH + 5;
   localparam int unsigned CNT_W      = $clog2(FRAME_BITS + 2);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
   localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);
   localparam logic [3:0]       SYNC_NIB = 4'hA;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_CHECK = 2'd2;

   // Synchronizers: [0] first stage, [1] synced value, [2] edge-detect history
   logic [2:0]            sck_sync_q,  sck_sync_d;
   logic [1:0]            mosi_sync_q, mosi_sync_d;
   logic [2:0]            csn_sync_q,  csn_sync_d;

   logic [1:0]            state_q, state_d;
   logic [CNT_W-1:0]      cnt_q,   cnt_d;
   logic                  ovr_q,   ovr_d;
   logic                  pend_q,  pend_d;
   logic [FRAME_BITS-1:0] sr_q,    sr_d;
   logic [WDT_W-1:0]      wdt_q,   wdt_d;
   logic [WIDTH-1:0]      out_q,   out_d;
   logic                  ok_q,    ok_d;
   logic                  err_q,   err_d;
   logic                  trip_q,  trip_d;

   logic                  sck_rise_c;
   logic                  csn_fall_c;
   logic                  csn_rise_c;
   logic                  frame_valid_c;

   // Edge detection on the synchronized inputs
   always_comb begin
      sck_rise_c = sck_sync_q[1] & ~sck_sync_q[2];
      csn_fall_c = ~csn_sync_q[1] & csn_sync_q[2];
      csn_rise_c = csn_sync_q[1] & ~csn_sync_q[2];
   end

   // Frame acceptance: exact length, no overrun, sync nibble, even parity
   always_comb begin
      frame_valid_c = (cnt_q == CNT_FULL) && !ovr_q &&
                      (sr_q[FRAME_BITS-1 -: 4] == SYNC_NIB) &&
                      !(^sr_q[WIDTH:0]);
   end

   // Next-state, datapath and output logic
   always_comb begin
      sck_sync_d  = {sck_sync_q[1:0], SCK};
      mosi_sync_d = {mosi_sync_q[0], MOSI};
      csn_sync_d  = {csn_sync_q[1:0], CS_N};
      state_d     = state_q;
      cnt_d       = cnt_q;
      ovr_d       = ovr_q;
      pend_d      = pend_q;
      sr_d        = sr_q;
      wdt_d       = wdt_q;
      out_d       = out_q;
      ok_d        = 1'b0;
      err_d       = 1'b0;
      trip_d      = trip_q;

      case (state_q)
         ST_IDLE: begin
            // A CS_N fall seen during CHECK is held in pend_q until now
            if (csn_fall_c || pend_q) begin
               state_d = ST_SHIFT;
               cnt_d   = '0;
               ovr_d   = 1'b0;
               pend_d  = 1'b0;
            end
         end
         ST_SHIFT: begin
            if (sck_rise_c) begin
               sr_d = {sr_q[FRAME_BITS-2:0], mosi_sync_q[1]};
               if (cnt_q != CNT_SAT) begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
               if (cnt_q == CNT_FULL) begin
                  ovr_d = 1'b1;
               end
            end
            if (csn_rise_c) begin
               state_d = ST_CHECK;
            end
         end
         ST_CHECK: begin
            state_d = ST_IDLE;
            if (csn_fall_c) begin
               pend_d = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // A valid commit takes priority over a same-cycle watchdog expiry
      if ((state_q == ST_CHECK) && frame_valid_c) begin
         out_d  = sr_q[WIDTH:1];
         ok_d   = 1'b1;
         trip_d = 1'b0;
         wdt_d  = WDT_CYCLES;
      end else begin
         if (state_q == ST_CHECK) begin
            err_d = 1'b1;
         end
         if ((WDT_CYCLES != '0) && (wdt_q != '0)) begin
            wdt_d = wdt_q - WDT_W'(1);
            if (wdt_q == WDT_W'(1)) begin
               out_d  = SAFE_VALUE;
               trip_d = 1'b1;
            end
         end
      end
   end

   // State registers
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         sck_sync_q  <= 3'b111;
         mosi_sync_q <= 2'b00;
         csn_sync_q  <= 3'b111;
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         ovr_q       <= 1'b0;
         pend_q      <= 1'b0;
         sr_q        <= '0;
         wdt_q       <= WDT_CYCLES;
         out_q       <= SAFE_VALUE;
         ok_q        <= 1'b0;
         err_q       <= 1'b0;
         trip_q      <= 1'b0;
      end else begin
         sck_sync_q  <= sck_sync_d;
         mosi_sync_q <= mosi_sync_d;
         csn_sync_q  <= csn_sync_d;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         ovr_q       <= ovr_d;
         pend_q      <= pend_d;
         sr_q        <= sr_d;
         wdt_q       <= wdt_d;
         out_q       <= out_d;
         ok_q        <= ok_d;
         err_q       <= err_d;
         trip_q      <= trip_d;
      end
   end

   assign OUT_DATA  = out_q;
   assign FRAME_OK  = ok_q;
   assign FRAME_ERR = err_q;
   assign WDT_TRIP  = trip_q;

endmodule

// File: tb/tb_out_frame_latch.sv
// ----------------------------------------------------------------------------
// tb_out_frame_latch
//   Directed bench for out_frame_latch. u_dut runs with a 100-cycle watchdog,
//   u_nw with the watchdog disabled; both see the same serial link.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_out_frame_latch;

   logic       CLK = 1'b0;
   logic       RST_N = 1'b0;
   logic       SCK = 1'b0;
   logic       MOSI = 1'b0;
   logic       CS_N = 1'b1;

   logic [8:0] out_a, out_b;
   logic       ok_a, ok_b, err_a, err_b, trip_a, trip_b;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   // Results of the last end_frame call
   int oka, erra, okb, errb, lat, okc;
   int e0, e1, e5;

   out_frame_latch #(
      .WIDTH(9), .SAFE_VALUE(9'h000), .WDT_W(20), .WDT_CYCLES(20'd100)
   ) u_dut (
      .CLK(CLK), .RST_N(RST_N), .SCK(SCK), .MOSI(MOSI), .CS_N(CS_N),
      .OUT_DATA(out_a), .FRAME_OK(ok_a), .FRAME_ERR(err_a), .WDT_TRIP(trip_a)
   );

   out_frame_latch #(
      .WIDTH(9), .SAFE_VALUE(9'h000), .WDT_W(20), .WDT_CYCLES(20'd0)
   ) u_nw (
      .CLK(CLK), .RST_N(RST_N), .SCK(SCK), .MOSI(MOSI), .CS_N(CS_N),
      .OUT_DATA(out_b), .FRAME_OK(ok_b), .FRAME_ERR(err_b), .WDT_TRIP(trip_b)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   // Drop CS_N and clock out n bits (bits[n-1] first), 3 CLK per SCK phase
   task automatic send_bits(input logic [15:0] bits, input int n);
      CS_N = 1'b0;
      SCK  = 1'b0;
      tick(2);
      for (int i = n - 1; i >= 0; i--) begin
         MOSI = bits[i];
         SCK  = 1'b0;
         tick(3);
         SCK  = 1'b1;
         tick(3);
      end
      SCK = 1'b0;
      tick(3);
   endtask

   // Raise CS_N and watch both instances for 6 cycles
   task automatic end_frame();
      CS_N = 1'b1;
      oka = 0; erra = 0; okb = 0; errb = 0; lat = 0; okc = -1;
      for (int i = 1; i <= 6; i++) begin
         tick(1);
         if (ok_a === 1'b1) begin
            oka++;
            if (lat == 0) begin
               lat = i;
               okc = cyc;
            end
         end
         if (err_a === 1'b1) erra++;
         if (ok_b === 1'b1) okb++;
         if (err_b === 1'b1) errb++;
      end
   endtask

   task automatic test_reset();
      RST_N = 1'b0;
      tick(3);
      checks++; if (out_a !== 9'h000) begin errors++; $display("FAIL reset_out_a: got %h expected %h", out_a, 9'h000); end
      checks++; if (out_b !== 9'h000) begin errors++; $display("FAIL reset_out_b: got %h expected %h", out_b, 9'h000); end
      checks++; if (trip_a !== 1'b0) begin errors++; $display("FAIL reset_trip: got %b expected 0", trip_a); end
      checks++; if ({ok_a, err_a, ok_b, err_b} !== 4'b0000) begin errors++; $display("FAIL reset_pulses: got %b expected 0000", {ok_a, err_a, ok_b, err_b}); end
      RST_N = 1'b1;
      tick(2);
      checks++; if ({ok_a, err_a, ok_b, err_b} !== 4'b0000) begin errors++; $display("FAIL post_reset_pulses: got %b expected 0000", {ok_a, err_a, ok_b, err_b}); end
   endtask

   task automatic test_valid_frame();
      send_bits(16'b00_1010_101010101_1, 14);
      end_frame();
      checks++; if (oka != 1 || erra != 0) begin errors++; $display("FAIL valid_pulses_a: got ok=%0d err=%0d expected ok=1 err=0", oka, erra); end
      checks++; if (okb != 1 || errb != 0) begin errors++; $display("FAIL valid_pulses_b: got ok=%0d err=%0d expected ok=1 err=0", okb, errb); end
      checks++; if (lat < 1 || lat > 5) begin errors++; $display("FAIL valid_latency: got %0d expected 1..5", lat); end
      checks++; if (out_a !== 9'h155) begin errors++; $display("FAIL valid_out_a: got %h expected %h", out_a, 9'h155); end
      checks++; if (out_b !== 9'h155) begin errors++; $display("FAIL valid_out_b: got %h expected %h", out_b, 9'h155); end
      checks++; if (trip_a !== 1'b0) begin errors++; $display("FAIL valid_trip: got %b expected 0", trip_a); end
      e0 = okc;
   endtask

   task automatic test_watchdog();
      while (cyc < e0 + 99) tick(1);
      checks++; if (trip_a !== 1'b0 || out_a !== 9'h155) begin errors++; $display("FAIL wdt_before: got trip=%b out=%h expected trip=0 out=155", trip_a, out_a); end
      tick(1);
      checks++; if (trip_a !== 1'b1 || out_a !== 9'h000) begin errors++; $display("FAIL wdt_expire: got trip=%b out=%h expected trip=1 out=000", trip_a, out_a); end
      checks++; if (trip_b !== 1'b0 || out_b !== 9'h155) begin errors++; $display("FAIL wdt_disabled: got trip=%b out=%h expected trip=0 out=155", trip_b, out_b); end
      tick(10);
      checks++; if (trip_a !== 1'b1 || out_a !== 9'h000) begin errors++; $display("FAIL wdt_hold: got trip=%b out=%h expected trip=1 out=000", trip_a, out_a); end
      send_bits(16'b00_1010_111111111_1, 14);
      end_frame();
      checks++; if (oka != 1 || out_a !== 9'h1FF) begin errors++; $display("FAIL wdt_recover_out: got ok=%0d out=%h expected ok=1 out=1ff", oka, out_a); end
      checks++; if (trip_a !== 1'b0) begin errors++; $display("FAIL wdt_recover_trip: got %b expected 0", trip_a); end
      checks++; if (out_b !== 9'h1FF) begin errors++; $display("FAIL wdt_recover_out_b: got %h expected %h", out_b, 9'h1FF); end
      e1 = okc;
   endtask

   // Commit lands on edge e1+100, the same edge the watchdog reaches zero
   task automatic test_wdt_race();
      send_bits(16'b00_1010_101010101_1, 14);
      checks++; if (cyc > e1 + 96) begin errors++; $display("FAIL race_setup: got cyc=%0d expected <= %0d", cyc, e1 + 96); end
      while (cyc < e1 + 96) tick(1);
      end_frame();
      checks++; if (okc != e1 + 100) begin errors++; $display("FAIL race_commit_cycle: got %0d expected %0d", okc, e1 + 100); end
      checks++; if (out_a !== 9'h155 || trip_a !== 1'b0) begin errors++; $display("FAIL race_commit_wins: got out=%h trip=%b expected out=155 trip=0", out_a, trip_a); end
      e5 = okc;
      while (cyc < e5 + 99) tick(1);
      checks++; if (trip_a !== 1'b0) begin errors++; $display("FAIL race_reload_early: got trip=%b expected 0", trip_a); end
      tick(1);
      checks++; if (trip_a !== 1'b1 || out_a !== 9'h000) begin errors++; $display("FAIL race_reload_expire: got trip=%b out=%h expected trip=1 out=000", trip_a, out_a); end
   endtask

   task automatic test_bad_frames();
      logic [15:0] pat [4];
      int          len [4];
      pat[0] = 16'b00_1010_101010101_0;  len[0] = 14;  // bad parity
      pat[1] = 16'b000_1010101010101;    len[1] = 13;  // short
      pat[2] = 16'b0_1010_101010101_10;  len[2] = 15;  // long
      pat[3] = 16'b00_1011_101010101_1;  len[3] = 14;  // bad sync
      send_bits(16'b00_1010_101010101_1, 14);
      end_frame();
      checks++; if (okb != 1 || out_b !== 9'h155) begin errors++; $display("FAIL bad_setup: got ok=%0d out=%h expected ok=1 out=155", okb, out_b); end
      for (int k = 0; k < 4; k++) begin
         send_bits(pat[k], len[k]);
         end_frame();
         checks++; if (erra != 1 || oka != 0) begin errors++; $display("FAIL bad%0d_pulses_a: got ok=%0d err=%0d expected ok=0 err=1", k, oka, erra); end
         checks++; if (errb != 1 || okb != 0) begin errors++; $display("FAIL bad%0d_pulses_b: got ok=%0d err=%0d expected ok=0 err=1", k, okb, errb); end
         checks++; if (out_b !== 9'h155) begin errors++; $display("FAIL bad%0d_out_hold: got %h expected %h", k, out_b, 9'h155); end
      end
   endtask

   task automatic test_reset_midframe();
      logic [15:0] fr;
      fr = 16'b00_1010_101010101_1;
      CS_N = 1'b0;
      SCK  = 1'b0;
      tick(2);
      for (int i = 13; i >= 7; i--) begin
         MOSI = fr[i];
         SCK  = 1'b0;
         tick(3);
         SCK  = 1'b1;
         tick(3);
      end
      RST_N = 1'b0;
      #1;
      checks++; if (out_b !== 9'h000) begin errors++; $display("FAIL midrst_async_out: got %h expected %h", out_b, 9'h000); end
      checks++; if (trip_a !== 1'b0) begin errors++; $display("FAIL midrst_async_trip: got %b expected 0", trip_a); end
      CS_N = 1'b1;
      SCK  = 1'b0;
      tick(2);
      RST_N = 1'b1;
      oka = 0; erra = 0; okb = 0; errb = 0;
      for (int i = 0; i < 8; i++) begin
         tick(1);
         if (ok_a === 1'b1) oka++;
         if (err_a === 1'b1) erra++;
         if (ok_b === 1'b1) okb++;
         if (err_b === 1'b1) errb++;
      end
      checks++; if (oka + erra + okb + errb != 0) begin errors++; $display("FAIL midrst_no_pulse: got %0d pulses expected 0", oka + erra + okb + errb); end
      checks++; if (out_a !== 9'h000 || out_b !== 9'h000) begin errors++; $display("FAIL midrst_out: got a=%h b=%h expected 000", out_a, out_b); end
      send_bits(16'b00_1010_111111111_1, 14);
      end_frame();
      checks++; if (oka != 1 || out_a !== 9'h1FF) begin errors++; $display("FAIL midrst_next_a: got ok=%0d out=%h expected ok=1 out=1ff", oka, out_a); end
      checks++; if (okb != 1 || out_b !== 9'h1FF) begin errors++; $display("FAIL midrst_next_b: got ok=%0d out=%h expected ok=1 out=1ff", okb, out_b); end
   endtask

   initial begin
      test_reset();
      test_valid_frame();
      test_watchdog();
      test_wdt_race();
      test_bad_frames();
      test_reset_midframe();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
